// File: rtl/game_state_ctrl_if.sv
// Signal bundle between the game state controller and the video/input logic around it.
// The controller takes the slave side; whoever drives vsync, buttons and deaths takes master.
interface game_state_ctrl_if;
  logic       vsync;
  logic       btn_start;
  logic       btn_pause;
  logic       p1_dead;
  logic       p2_dead;
  logic [2:0] game_state;
  logic [1:0] winner;
  logic [1:0] countdown_sec;
  logic       round_rst;

  modport master (
    output vsync, btn_start, btn_pause, p1_dead, p2_dead,
    input  game_state, winner, countdown_sec, round_rst
  );

  modport slave (
    input  vsync, btn_start, btn_pause, p1_dead, p2_dead,
    output game_state, winner, countdown_sec, round_rst
  );
endinterface

// File: rtl/game_state_ctrl.sv
// Top-level game sequencer: menu, countdown, play, pause and game-over, timed in vsync frames.
// Latches the round winner and pulses round_rst whenever a new round begins.
module game_state_ctrl #(
  parameter int FRAMES_PER_SEC = 60,
  parameter int COUNTDOWN_SEC  = 3,
  parameter int OVER_FRAMES    = 180
) (
  input  logic             i_clk,
  input  logic             i_rst,
  game_state_ctrl_if.slave bus
);

  localparam int CNT_MAX = (FRAMES_PER_SEC > OVER_FRAMES) ? FRAMES_PER_SEC : OVER_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SEC_LAST  = CNT_W'(FRAMES_PER_SEC - 1);
  localparam logic [CNT_W-1:0] OVER_LAST = CNT_W'(OVER_FRAMES - 1);
  localparam logic [1:0]       CD_START  = 2'(COUNTDOWN_SEC);

  typedef enum logic [2:0] {
    ST_MENU      = 3'b000,
    ST_COUNTDOWN = 3'b001,
    ST_PLAY      = 3'b010,
    ST_PAUSE     = 3'b011,
    ST_OVER      = 3'b100
  } state_t;

  state_t           r_state;
  logic [1:0]       r_winner;
  logic [1:0]       r_countdownSec;
  logic             r_roundRst;
  logic [CNT_W-1:0] r_frameCnt;
  logic             r_vsyncD;
  logic             r_startD;
  logic             r_pauseD;

  logic w_frameTick;
  logic w_startRise;
  logic w_pauseRise;

  assign w_frameTick = bus.vsync & ~r_vsyncD;
  assign w_startRise = bus.btn_start & ~r_startD;
  assign w_pauseRise = bus.btn_pause & ~r_pauseD;

  assign bus.game_state    = r_state;
  assign bus.winner        = r_winner;
  assign bus.countdown_sec = r_countdownSec;
  assign bus.round_rst     = r_roundRst;

  // Delay registers load the live inputs in reset so a button held through reset yields no edge.
  always_ff @(posedge i_clk) begin
    r_vsyncD <= bus.vsync;
    r_startD <= bus.btn_start;
    r_pauseD <= bus.btn_pause;

    if (i_rst) begin
      r_state        <= ST_MENU;
      r_winner       <= 2'b00;
      r_countdownSec <= 2'd0;
      r_roundRst     <= 1'b0;
      r_frameCnt     <= '0;
    end else begin
      r_roundRst <= 1'b0;

      case (r_state)
        ST_MENU: begin
          if (w_startRise) begin
            r_state        <= ST_COUNTDOWN;
            r_frameCnt     <= '0;
            r_countdownSec <= CD_START;
            r_winner       <= 2'b00;
            r_roundRst     <= 1'b1;
          end
        end

        ST_COUNTDOWN: begin
          if (w_frameTick) begin
            if (r_frameCnt == SEC_LAST) begin
              r_frameCnt <= '0;
              if (r_countdownSec == 2'd1) begin
                r_state        <= ST_PLAY;
                r_countdownSec <= 2'd0;
              end else begin
                r_countdownSec <= r_countdownSec - 2'd1;
              end
            end else begin
              r_frameCnt <= r_frameCnt + 1'b1;
            end
          end
        end

        // Deaths outrank a pause press arriving on the same cycle.
        ST_PLAY: begin
          if (bus.p1_dead && bus.p2_dead) begin
            r_state    <= ST_OVER;
            r_winner   <= 2'b11;
            r_frameCnt <= '0;
          end else if (bus.p2_dead) begin
            r_state    <= ST_OVER;
            r_winner   <= 2'b01;
            r_frameCnt <= '0;
          end else if (bus.p1_dead) begin
            r_state    <= ST_OVER;
            r_winner   <= 2'b10;
            r_frameCnt <= '0;
          end else if (w_pauseRise) begin
            r_state    <= ST_PAUSE;
            r_frameCnt <= '0;
          end
        end

        ST_PAUSE: begin
          if (w_pauseRise) begin
            r_state    <= ST_PLAY;
            r_frameCnt <= '0;
          end
        end

        // A fresh start beats the automatic timeout back to the menu.
        ST_OVER: begin
          if (w_startRise) begin
            r_state        <= ST_COUNTDOWN;
            r_frameCnt     <= '0;
            r_countdownSec <= CD_START;
            r_winner       <= 2'b00;
            r_roundRst     <= 1'b1;
          end else if (w_frameTick) begin
            if (r_frameCnt == OVER_LAST) begin
              r_state    <= ST_MENU;
              r_frameCnt <= '0;
              r_winner   <= 2'b00;
            end else begin
              r_frameCnt <= r_frameCnt + 1'b1;
            end
          end
        end

        default: begin
          r_state        <= ST_MENU;
          r_frameCnt     <= '0;
          r_winner       <= 2'b00;
          r_countdownSec <= 2'd0;
        end
      endcase
    end
  end

endmodule
